// File: rtl/oe_bus_arbiter_if.sv
// Shared-bus bundle between the requesting sub-blocks and oe_bus_arbiter.
// The arbiter uses the slave modport; requesters (or a bench) use master.
interface oe_bus_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*WIDTH-1:0] req_oe;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      o;
    logic [WIDTH-1:0]      oe;
    logic                  busy;
    logic                  err;

    modport master (
        output req, req_data, req_oe,
        input  gnt, o, oe, busy, err
    );

    modport slave (
        input  req, req_data, req_oe,
        output gnt, o, oe, busy, err
    );
endinterface

// File: rtl/oe_bus_arbiter.sv
// Round-robin owner of a shared o/oe bus with a one-cycle turnaround between owners.
// Define OE_BUS_ARB_CONFLICT_EN to build the sticky non-owner-enable checker on err.
module oe_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    oe_bus_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NREQ);
    localparam int HW   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NREQ - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]       state;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] o_p1;
    logic [WIDTH-1:0] oe_p1;
    logic [IDXW-1:0]  last;
    logic [IDXW-1:0]  own;
    logic [HW-1:0]    hold;

    logic             sel_vld;
    logic [IDXW-1:0]  sel_idx;
    logic [IDXW-1:0]  cand;
    logic             others;

    // Scan downwards so the candidate nearest to last+1 is the one left standing.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int j = NREQ; j >= 1; j--) begin
            cand = IDXW'((int'(last) + j) % NREQ);
            if (bus.req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // gnt_q is one-hot on the owner while driving, so this is "someone else wants the bus".
    assign others = |(bus.req & ~gnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt_q <= '0;
            o_p1  <= '0;
            oe_p1 <= '0;
            last  <= LAST_RST;
            own   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    oe_p1 <= '0;
                    if (sel_vld) begin
                        state <= ST_DRIVE;
                        gnt_q <= NREQ'(1) << sel_idx;
                        own   <= sel_idx;
                        hold  <= '0;
                    end
                end
                ST_DRIVE: begin
                    o_p1  <= bus.req_data[int'(own)*WIDTH +: WIDTH];
                    oe_p1 <= bus.req_oe[int'(own)*WIDTH +: WIDTH];
                    if (hold != HOLD_LAST) begin
                        hold <= hold + 1'b1;
                    end
                    if (!bus.req[own] || (hold == HOLD_LAST && others)) begin
                        state <= ST_TURN;
                        gnt_q <= '0;
                        last  <= own;
                    end
                end
                ST_TURN: begin
                    oe_p1 <= '0;
                    if (sel_vld) begin
                        state <= ST_DRIVE;
                        gnt_q <= NREQ'(1) << sel_idx;
                        own   <= sel_idx;
                        hold  <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_q <= '0;
                    oe_p1 <= '0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.o    = o_p1;
    assign bus.oe   = oe_p1;
    assign bus.busy = (state != ST_IDLE);

`ifdef OE_BUS_ARB_CONFLICT_EN
    logic err_q;
    logic conflict;

    // Outside DRIVE gnt_q is zero, so every requester counts as a non-owner there.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_q[i] && (|bus.req_oe[i*WIDTH +: WIDTH])) begin
                conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (conflict) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_oe_bus_arbiter.sv
// Scoreboard bench for oe_bus_arbiter: the driver pushes model predictions, a monitor pops and compares.
module tb_oe_bus_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oe_bus_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

    oe_bus_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [W-1:0] o;
        logic [W-1:0] oe;
        logic         busy;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc_no = 0;

    // Reference model: who owns the bus, for how long, and whether a gap cycle is due.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_last  = N - 1;
    bit         m_gap   = 1'b0;
    logic [W-1:0] m_o   = '0;
    logic [W-1:0] m_oe  = '0;
    logic       m_err   = 1'b0;

    logic [N*W-1:0] dv;
    logic [N*W-1:0] ev;
    logic [N-1:0]   rq;
    logic           rr;

    function automatic logic [N*W-1:0] rnd_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d, input logic [N*W-1:0] e);
        exp_t x;
        bit   oth;
        if (r) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_gap = 1'b0;
            m_o = '0; m_oe = '0; m_err = 1'b0;
        end else begin
`ifdef OE_BUS_ARB_CONFLICT_EN
            for (int i = 0; i < N; i++)
                if (i != m_owner && e[i*W +: W] != '0) m_err = 1'b1;
`endif
            if (m_owner >= 0) begin
                m_o  = d[m_owner*W +: W];
                m_oe = e[m_owner*W +: W];
                m_held++;
                oth = 1'b0;
                for (int i = 0; i < N; i++)
                    if (i != m_owner && q[i]) oth = 1'b1;
                if (!q[m_owner] || (m_held >= MH && oth)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_gap   = 1'b1;
                end
            end else begin
                m_oe  = '0;
                m_gap = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (q[c]) begin
                        m_owner = c;
                        m_held  = 0;
                        break;
                    end
                end
            end
        end
        x.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        x.o    = m_o;
        x.oe   = m_oe;
        x.busy = (m_owner >= 0) || m_gap;
        x.err  = m_err;
        sbq.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d, input logic [N*W-1:0] e);
        @(posedge clk);
        #2;
        rst          = r;
        bus.req      = q;
        bus.req_data = d;
        bus.req_oe   = e;
        step(r, q, d, e);
        cyc_no++;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_no, act, want);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("gnt",  W'(bus.gnt),  W'(x.gnt));
                chk("o",    bus.o,        x.o);
                chk("oe",   bus.oe,       x.oe);
                chk("busy", W'(bus.busy), W'(x.busy));
                chk("err",  W'(bus.err),  W'(x.err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_oe = '0;

        // reset with random inputs, then idle
        repeat (2) cyc(1'b1, N'($urandom), rnd_vec(), rnd_vec());
        repeat (3) cyc(1'b0, '0, rnd_vec(), '0);

        // single owner holding indefinitely
        dv = rnd_vec(); ev = '0;
        dv[0 +: W] = 32'h12345679;
        ev[0 +: W] = 32'hFFFF_FFFF;
        repeat (20) cyc(1'b0, 4'b0001, dv, ev);
        repeat (2) cyc(1'b0, '0, dv, '0);

        // all requesting: round robin with pre-emption
        repeat (45) cyc(1'b0, 4'b1111, rnd_vec(), rnd_vec());

        // turnaround from owner 1 to pending requester 2
        cyc(1'b1, '0, '0, '0);
        dv = rnd_vec(); ev = '0;
        ev[1*W +: W] = 32'h0000_0001;
        ev[2*W +: W] = 32'hab345679;
        repeat (3) cyc(1'b0, 4'b0010, dv, ev);
        repeat (3) cyc(1'b0, 4'b0110, dv, ev);
        repeat (5) cyc(1'b0, 4'b0100, dv, ev);

        // reset during owner 2's third drive cycle, then everybody requests
        cyc(1'b1, '0, '0, '0);
        repeat (3) cyc(1'b0, 4'b0100, rnd_vec(), '0);
        cyc(1'b1, 4'b0100, rnd_vec(), '0);
        repeat (4) cyc(1'b0, 4'b1111, rnd_vec(), '0);

        // non-owner 3 enabling while owner 0 holds the bus
        cyc(1'b1, '0, '0, '0);
        dv = rnd_vec(); ev = '0;
        repeat (3) cyc(1'b0, 4'b0001, dv, '0);
        ev[3*W +: W] = 32'h1;
        cyc(1'b0, 4'b0001, dv, ev);
        repeat (4) cyc(1'b0, 4'b0001, dv, '0);
        cyc(1'b1, '0, '0, '0);
        repeat (2) cyc(1'b0, '0, '0, '0);

        // random traffic with occasional reset
        rq = N'($urandom);
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) rq = N'($urandom);
            rr = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++)
                ev[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            cyc(rr, rq, rnd_vec(), ev);
        end

        @(posedge clk);
        #5;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain cycle=%0d got=%0d want=0", cyc_no, sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
